// File: rtl/binary_stream_thresh_pkg.sv
// Shared constants and types for the gray-to-binary stream thresholder.
package binary_pkg;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_MEAN  = 2'd1;
  localparam logic [1:0] MODE_HYST  = 2'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/binary_stream_thresh_if.sv
// Pixel stream bundle: gray pixels in, binary pixels out, each with valid/sof/eof.
interface binary_stream_thresh_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_sof;
  logic              in_eof;
  logic [DATA_W-1:0] gray;
  logic              out_valid;
  logic              out_sof;
  logic              out_eof;
  logic [DATA_W-1:0] binary;

  modport master (
    output in_valid, in_sof, in_eof, gray,
    input  out_valid, out_sof, out_eof, binary
  );

  modport slave (
    input  in_valid, in_sof, in_eof, gray,
    output out_valid, out_sof, out_eof, binary
  );
endinterface

// File: rtl/binary_stream_thresh_mean_acc.sv
// Per-frame pixel sum and count; publishes the frame mean on a well-formed
// eof and flags short/long or aborted frames.
module binary_mean_acc #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PIX_LOG2    = 14,
  parameter int unsigned INIT_THRESH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  input  logic              sof,
  input  logic              eof,
  input  logic              abort,
  input  logic [DATA_W-1:0] gray,
  output logic [DATA_W-1:0] mean,
  output logic              frame_err
);
  localparam int unsigned SUM_W = DATA_W + PIX_LOG2 + 1;
  localparam int unsigned CNT_W = PIX_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << PIX_LOG2);

  logic [SUM_W-1:0]  sum_q,  sum_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [DATA_W-1:0] mean_q, mean_d;
  logic              err_q,  err_d;

  // Accumulate the accepted pixel; the eof check uses the totals including it.
  always_comb begin
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    mean_d = mean_q;
    err_d  = 1'b0;
    if (beat) begin
      if (sof) begin
        sum_d = SUM_W'(gray);
        cnt_d = CNT_W'(1);
      end else begin
        sum_d = sum_q + SUM_W'(gray);
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
      if (eof) begin
        if (cnt_d == CNT_FULL) mean_d = DATA_W'(sum_d >> PIX_LOG2);
        else                   err_d  = 1'b1;
      end
    end
    if (abort) err_d = 1'b1;
  end

  // Accumulator, mean and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cnt_q  <= '0;
      mean_q <= DATA_W'(INIT_THRESH);
      err_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      mean_q <= mean_d;
      err_q  <= err_d;
    end
  end

  assign mean      = mean_q;
  assign frame_err = err_q;
endmodule

// File: rtl/binary_stream_thresh.sv
// Streaming gray-to-binary thresholder: fixed, frame-mean adaptive or
// hysteresis compare, two-cycle pipeline with matched sof/eof markers.
module binary_stream_thresh
  import binary_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PIX_LOG2    = 14,
  parameter int unsigned INIT_THRESH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  binary_stream_thresh_if.slave  strm,
  input  logic [1:0]             cfg_mode,
  input  logic [DATA_W-1:0]      cfg_th_lo,
  input  logic [DATA_W-1:0]      cfg_th_hi,
  input  logic                   cfg_invert,
  output logic [DATA_W-1:0]      cur_thresh,
  output logic                   frame_err
);
  frame_state_t state_q, state_d;
  logic accept, abort, start;

  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] thr_q,  thr_d;
  logic [DATA_W-1:0] hi_q,   hi_d;
  logic              inv_q,  inv_d;
  logic              hyst_q, hyst_d;
  logic              pix_hi;
  logic [DATA_W-1:0] mean;

  logic              s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
  logic              s1_hi_q, s1_hi_d, s1_inv_q, s1_inv_d;
  logic              out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic [DATA_W-1:0] binary_q, binary_d;

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next frame state: sof always (re)starts a frame, eof closes it.
  always_comb begin
    state_d = state_q;
    if (strm.in_valid) begin
      if (strm.in_sof)                          state_d = strm.in_eof ? IDLE : ACTIVE;
      else if (state_q == ACTIVE && strm.in_eof) state_d = IDLE;
    end
  end

  // Beat classification: accepted pixel, frame start, aborting restart.
  always_comb begin
    start  = strm.in_valid & strm.in_sof;
    accept = strm.in_valid & (strm.in_sof | (state_q == ACTIVE));
    abort  = start & (state_q == ACTIVE);
  end

  // Config latch; the _d values double as the settings for the current beat,
  // so the sof pixel is compared with its own frame's fresh config.
  always_comb begin
    mode_d = mode_q;
    thr_d  = thr_q;
    hi_d   = hi_q;
    inv_d  = inv_q;
    if (start) begin
      mode_d = cfg_mode;
      thr_d  = (cfg_mode == MODE_MEAN) ? mean : cfg_th_lo;
      hi_d   = cfg_th_hi;
      inv_d  = cfg_invert;
    end
  end

  // Stage 1 compare; hysteresis memory is forced to 0 on the sof pixel.
  always_comb begin
    hyst_d = hyst_q;
    if (mode_d == MODE_HYST) begin
      if (strm.gray >= hi_d)     pix_hi = 1'b1;
      else if (strm.gray < thr_d) pix_hi = 1'b0;
      else                        pix_hi = start ? 1'b0 : hyst_q;
    end else begin
      pix_hi = (strm.gray >= thr_d);
    end
    if (accept) hyst_d = pix_hi;
  end

  // Pipeline stage contents.
  always_comb begin
    s1_valid_d  = accept;
    s1_sof_d    = accept & strm.in_sof;
    s1_eof_d    = accept & strm.in_eof;
    s1_hi_d     = pix_hi;
    s1_inv_d    = inv_d;
    out_valid_d = s1_valid_q;
    out_sof_d   = s1_sof_q;
    out_eof_d   = s1_eof_q;
    binary_d    = s1_valid_q ? {DATA_W{s1_hi_q ^ s1_inv_q}} : '0;
  end

  // Config, hysteresis and pipeline registers; reset flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_FIXED;
      thr_q       <= '0;
      hi_q        <= '0;
      inv_q       <= 1'b0;
      hyst_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s1_hi_q     <= 1'b0;
      s1_inv_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      binary_q    <= '0;
    end else begin
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      hi_q        <= hi_d;
      inv_q       <= inv_d;
      hyst_q      <= hyst_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_eof_q    <= s1_eof_d;
      s1_hi_q     <= s1_hi_d;
      s1_inv_q    <= s1_inv_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      binary_q    <= binary_d;
    end
  end

  binary_mean_acc #(
    .DATA_W      (DATA_W),
    .PIX_LOG2    (PIX_LOG2),
    .INIT_THRESH (INIT_THRESH)
  ) u_mean_acc (
    .clk       (clk),
    .rst       (rst),
    .beat      (accept),
    .sof       (strm.in_sof),
    .eof       (strm.in_eof),
    .abort     (abort),
    .gray      (strm.gray),
    .mean      (mean),
    .frame_err (frame_err)
  );

  assign strm.out_valid = out_valid_q;
  assign strm.out_sof   = out_sof_q;
  assign strm.out_eof   = out_eof_q;
  assign strm.binary    = binary_q;
  assign cur_thresh     = thr_q;
endmodule

// File: tb/tb_binary_stream_thresh.sv
// Directed bench for binary_stream_thresh with an expected-output queue.
module tb_binary_stream_thresh;
  localparam int unsigned DW = 8;
  localparam int unsigned PL = 2;

  typedef struct {
    logic [DW-1:0] bin;
    logic          sof;
    logic          eof;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [DW-1:0] cfg_th_lo = 8'd128;
  logic [DW-1:0] cfg_th_hi = 8'd255;
  logic          cfg_invert = 1'b0;
  logic [DW-1:0] cur_thresh;
  logic          frame_err;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  binary_stream_thresh_if #(.DATA_W(DW)) bus ();

  binary_stream_thresh #(
    .DATA_W      (DW),
    .PIX_LOG2    (PL),
    .INIT_THRESH (128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .strm       (bus),
    .cfg_mode   (cfg_mode),
    .cfg_th_lo  (cfg_th_lo),
    .cfg_th_hi  (cfg_th_hi),
    .cfg_invert (cfg_invert),
    .cur_thresh (cur_thresh),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Output monitor: every out_valid beat must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("binary",  32'(bus.binary),  32'(e.bin));
        chk("out_sof", 32'(bus.out_sof), 32'(e.sof));
        chk("out_eof", 32'(bus.out_eof), 32'(e.eof));
      end
    end
  end

  task automatic beat(input logic [DW-1:0] g, input logic sof, input logic eof,
                      input bit push, input logic [DW-1:0] eb, input logic exp_err);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_eof   = eof;
    bus.gray     = g;
    if (push) begin
      e.bin = eb;
      e.sof = sof;
      e.eof = eof;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("frame_err", 32'(frame_err), 32'(exp_err));
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
    bus.gray     = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_binary",     32'(bus.binary),    32'd0);
    chk("rst_out_sof",    32'(bus.out_sof),   32'd0);
    chk("rst_out_eof",    32'(bus.out_eof),   32'd0);
    chk("rst_cur_thresh", 32'(cur_thresh),    32'd0);
    chk("rst_frame_err",  32'(frame_err),     32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fixed mode, th 128; 5-pixel frame is mis-sized so eof flags an error.
    cfg_mode = 2'd0; cfg_th_lo = 8'd128; cfg_invert = 1'b0;
    beat(8'd10,  1, 0, 1, 8'h00, 0);
    chk("fixed_cur_thresh", 32'(cur_thresh), 32'd128);
    beat(8'd100, 0, 0, 1, 8'h00, 0);
    beat(8'd128, 0, 0, 1, 8'hFF, 0);
    beat(8'd200, 0, 0, 1, 8'hFF, 0);
    beat(8'd255, 0, 1, 1, 8'hFF, 1);
    drain();

    // Beats outside a frame are dropped.
    beat(8'd255, 0, 0, 0, 8'h00, 0);
    beat(8'd255, 0, 1, 0, 8'h00, 0);
    drain();

    // Inverted; mid-frame threshold change must not apply.
    cfg_invert = 1'b1;
    beat(8'd10,  1, 0, 1, 8'hFF, 0);
    cfg_th_lo = 8'd0;
    beat(8'd100, 0, 0, 1, 8'hFF, 0);
    beat(8'd128, 0, 0, 1, 8'h00, 0);
    beat(8'd200, 0, 0, 1, 8'h00, 0);
    beat(8'd255, 0, 1, 1, 8'h00, 1);
    chk("inv_cur_thresh_held", 32'(cur_thresh), 32'd128);
    drain();

    // Mean-adaptive: frame A uses the initial 128, frame B uses A's mean 70.
    cfg_mode = 2'd1; cfg_invert = 1'b0;
    beat(8'd40,  1, 0, 1, 8'h00, 0);
    chk("meanA_cur_thresh", 32'(cur_thresh), 32'd128);
    beat(8'd60,  0, 0, 1, 8'h00, 0);
    beat(8'd80,  0, 0, 1, 8'h00, 0);
    beat(8'd100, 0, 1, 1, 8'h00, 0);
    drain();
    beat(8'd69,  1, 0, 1, 8'h00, 0);
    chk("meanB_cur_thresh", 32'(cur_thresh), 32'd70);
    beat(8'd70,  0, 0, 1, 8'hFF, 0);
    beat(8'd71,  0, 0, 1, 8'hFF, 0);
    beat(8'd0,   0, 1, 1, 8'h00, 0);
    drain();
    // 3-pixel frame: error, mean stays at 52 (from frame B).
    beat(8'd60,  1, 0, 1, 8'hFF, 0);
    chk("meanC_cur_thresh", 32'(cur_thresh), 32'd52);
    beat(8'd60,  0, 0, 1, 8'hFF, 0);
    beat(8'd60,  0, 1, 1, 8'hFF, 1);
    drain();
    beat(8'd51,  1, 0, 1, 8'h00, 0);
    chk("meanD_cur_thresh", 32'(cur_thresh), 32'd52);
    beat(8'd52,  0, 0, 1, 8'hFF, 0);
    beat(8'd53,  0, 0, 1, 8'hFF, 0);
    beat(8'd200, 0, 1, 1, 8'hFF, 0);
    drain();

    // Hysteresis lo 50 / hi 150.
    cfg_mode = 2'd2; cfg_th_lo = 8'd50; cfg_th_hi = 8'd150;
    beat(8'd100, 1, 0, 1, 8'h00, 0);
    chk("hyst_cur_thresh", 32'(cur_thresh), 32'd50);
    beat(8'd160, 0, 0, 1, 8'hFF, 0);
    beat(8'd100, 0, 0, 1, 8'hFF, 0);
    beat(8'd40,  0, 0, 1, 8'h00, 0);
    beat(8'd100, 0, 1, 1, 8'h00, 1);
    drain();
    beat(8'd200, 1, 0, 1, 8'hFF, 0);
    beat(8'd100, 0, 0, 1, 8'hFF, 0);
    beat(8'd100, 0, 0, 1, 8'hFF, 0);
    beat(8'd100, 0, 1, 1, 8'hFF, 0);
    drain();
    beat(8'd100, 1, 0, 1, 8'h00, 0);
    beat(8'd149, 0, 0, 1, 8'h00, 0);
    beat(8'd150, 0, 0, 1, 8'hFF, 0);
    beat(8'd49,  0, 1, 1, 8'h00, 0);
    drain();
    // Inverted thresholds: the high test wins.
    cfg_th_lo = 8'd200; cfg_th_hi = 8'd100;
    beat(8'd150, 1, 0, 1, 8'hFF, 0);
    beat(8'd50,  0, 0, 1, 8'h00, 0);
    beat(8'd250, 0, 0, 1, 8'hFF, 0);
    beat(8'd99,  0, 1, 1, 8'h00, 0);
    drain();

    // Second sof aborts and restarts with fresh config.
    cfg_mode = 2'd0; cfg_th_lo = 8'd128;
    beat(8'd200, 1, 0, 1, 8'hFF, 0);
    beat(8'd10,  0, 0, 1, 8'h00, 0);
    cfg_th_lo = 8'd5;
    beat(8'd10,  1, 0, 1, 8'hFF, 1);
    chk("abort_cur_thresh", 32'(cur_thresh), 32'd5);
    beat(8'd3,   0, 0, 1, 8'h00, 0);
    beat(8'd200, 0, 0, 1, 8'hFF, 0);
    beat(8'd4,   0, 1, 1, 8'h00, 0);
    drain();

    // Single-pixel frame, then FSM must be idle again.
    cfg_th_lo = 8'd128;
    beat(8'd200, 1, 1, 1, 8'hFF, 1);
    beat(8'd200, 0, 0, 0, 8'h00, 0);
    drain();

    // Reset mid-frame flushes the pipeline and restores the initial mean.
    beat(8'd200, 1, 0, 1, 8'hFF, 0);
    beat(8'd200, 0, 0, 1, 8'hFF, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("midrst_binary",     32'(bus.binary),    32'd0);
    chk("midrst_cur_thresh", 32'(cur_thresh),    32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cfg_mode = 2'd1;
    beat(8'd127, 1, 0, 1, 8'h00, 0);
    chk("postrst_cur_thresh", 32'(cur_thresh), 32'd128);
    beat(8'd128, 0, 0, 1, 8'hFF, 0);
    beat(8'd129, 0, 0, 1, 8'hFF, 0);
    beat(8'd255, 0, 1, 1, 8'hFF, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/binary_stream_thresh.md
Name: binary_stream_thresh

Overview:
- Parametrised successor to the fixed 8-bit gray-to-binary thresholder.
- Streaming block with valid and frame markers, a configurable data width, and a latency-matched frame-marker pipeline.
- Three threshold modes: fixed, frame-mean adaptive (the mean of frame N thresholds frame N+1), and hysteresis.
- Sits between the grayscale converter and downstream morphology/display stages of the image pipeline.

Parameters:
- DATA_W, 8, pixel width in bits.
- PIX_LOG2, 14, log2 of the expected pixels per frame; the mean is computed as sum >> PIX_LOG2.
- INIT_THRESH, 128, threshold used in adaptive mode before the first valid frame mean exists.

Ports:
- clk  in  1  pixel clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel qualifier.
- in_sof  in  1  first pixel of frame; qualified by in_valid.
- in_eof  in  1  last pixel of frame; qualified by in_valid.
- gray  in  DATA_W  input gray pixel.
- cfg_mode  in  2  0 = fixed, 1 = mean-adaptive, 2 = hysteresis, 3 = reserved (behaves as 0).
- cfg_th_lo  in  DATA_W  fixed threshold (modes 0/3); low threshold (mode 2).
- cfg_th_hi  in  DATA_W  high threshold (mode 2).
- cfg_invert  in  1  swap output polarity.
- out_valid  out  1  output pixel qualifier.
- out_sof  out  1  delayed in_sof.
- out_eof  out  1  delayed in_eof.
- binary  out  DATA_W  all-ones or all-zeros.
- cur_thresh  out  DATA_W  threshold applied to the current frame (mode 1); otherwise cfg_th_lo.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; mean register = INIT_THRESH; hysteresis state = 0; accumulator and pixel counter = 0.
- Latency: exactly 2 cycles, in_valid to out_valid; sof/eof travel in the same pipeline. No backpressure; one pixel per cycle maximum.
- Config latching: cfg_* are sampled only on the in_valid & in_sof beat and held for the whole frame. Mid-frame config changes have no effect.
- FSM: IDLE, ACTIVE.
  - IDLE: a valid & sof beat goes to ACTIVE. A valid beat without sof is dropped (no out_valid). An eof in IDLE is ignored.
  - ACTIVE: a valid & eof beat returns to IDLE after that pixel is processed. A beat with sof & eof together is a 1-pixel frame: processed, and the FSM stays in IDLE.
  - ACTIVE, second sof: the current frame is aborted, frame_err pulses, no mean update occurs, and a new frame starts on that beat with fresh config.
- Compare, stage 1:
  - Mode 0/3: pix_hi = gray >= th_lo.
  - Mode 1: pix_hi = gray >= mean register value latched at sof.
  - Mode 2: if gray >= th_hi then 1; else if gray < th_lo then 0; else the previous pixel's result.
  - Mode 2 state clears to 0 at each sof.
  - If th_lo > th_hi, the th_hi test takes priority.
- Output, stage 2: binary = {DATA_W{pix_hi ^ invert}}.
- Mean accumulator (all modes):
  - Width DATA_W+PIX_LOG2+1. Cleared on the sof beat, which also adds that pixel.
  - Pixel counter width PIX_LOG2+1, saturating at its maximum.
  - At eof: if count == 2**PIX_LOG2 exactly, the mean register updates to sum >> PIX_LOG2 on the following cycle. Otherwise frame_err pulses and the mean is unchanged.
- cur_thresh updates on the sof beat.
- Reset mid-frame: the pipeline is flushed and no partial outputs are emitted.

Decomposition:
- Shared package binary_pkg: mode localparams MODE_FIXED=0, MODE_MEAN=1, MODE_HYST=2; a frame-state enum {IDLE, ACTIVE}.
- One sub-module, binary_mean_acc: sum, count, eof check, mean register, error flag.
- Top level owns the FSM, config latch, compare stage, and output pipeline.

Test Plan:
- Mode 0, th_lo=128, invert=0. Stream 10, 100, 128, 200, 255 -> after 2 cycles, binary = 0x00, 0x00, 0xFF, 0xFF, 0xFF, with out_sof on the first pixel and out_eof on the last.
- Mode 0, invert=1 -> the same stream gives 0xFF, 0xFF, 0x00, 0x00, 0x00. Changing cfg_th_lo mid-frame has no effect until the next sof.
- Mode 1, PIX_LOG2=2:
  - Frame A = 40, 60, 80, 100 -> mean 70. Frame A itself uses 128, so all outputs are 0x00.
  - Frame B = 69, 70, 71, 0 -> cur_thresh = 70; binary = 00, FF, FF, 00.
- Mode 1, frame of 3 pixels -> frame_err pulses one cycle after eof; the mean stays at its previous value.
- Mode 2, lo=50, hi=150. Stream 100, 160, 100, 40, 100 -> 00, FF, FF, 00, 00. Hysteresis state clears at the next sof.
- Second sof at pixel 2 of a frame -> frame_err pulses. Assert rst mid-frame -> out_valid drops immediately, outputs 0; a clean frame afterwards processes correctly.
